matrix_op_sequencer: RTL

- Control block for the matrix coprocessor.
- Accepts one command (opcode + matrix size), collects operand elements byte-serially into 200-bit operand registers, and drives the combinational operation units (negation, add, sub, transpose, multiply).
- Waits a fixed settle time, captures the selected unit's result, and streams it back byte-serially with valid/ready flow control.
- Sits between the host-facing byte interface and the operation-unit mux.

---
 rtl/matrix_op_sequencer_if.sv | 37 +++
 rtl/matrix_op_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/matrix_op_sequencer_if.sv
// Host/unit-facing bundle of the matrix coprocessor sequencer: command, operand
// load, operation-unit mux and result stream channels.
interface matrix_op_sequencer_if #(
  parameter int MAX_ELEMS = 25
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [2:0]             cmd_op;
  logic [1:0]             cmd_size;
  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [2:0]             unit_op;
  logic [1:0]             unit_size;
  logic [MAX_ELEMS*8-1:0] unit_a;
  logic [MAX_ELEMS*8-1:0] unit_b;
  logic [MAX_ELEMS*8-1:0] unit_result;
  logic [7:0]             out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output cmd_valid, cmd_op, cmd_size, in_data, in_valid, unit_result, out_ready,
    input  cmd_ready, in_ready, unit_op, unit_size, unit_a, unit_b,
           out_data, out_valid, out_last, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_size, in_data, in_valid, unit_result, out_ready,
    output cmd_ready, in_ready, unit_op, unit_size, unit_a, unit_b,
           out_data, out_valid, out_last, busy, done, err
  );
endinterface

// File: rtl/matrix_op_sequencer.sv
// Matrix coprocessor control: takes one command, loads operands byte-serially,
// holds them for the operation units, then streams the captured result back.
module matrix_op_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int MAX_ELEMS   = 25
) (
  input logic                  clk,
  input logic                  rst_n,
  matrix_op_sequencer_if.slave bus
);
  localparam int BUS_W = MAX_ELEMS * 8;
  localparam int CNT_W = $clog2(MAX_ELEMS + 1);
  localparam int EXC_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [EXC_W-1:0] EXEC_LAST = EXC_W'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_STREAM, S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [EXC_W-1:0] exec_cnt;
  logic [2:0]       op_q;
  logic [1:0]       size_q;
  logic [BUS_W-1:0] a_q;
  logic [BUS_W-1:0] b_q;
  logic [BUS_W-1:0] res_q;
  logic             cmd_ready_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] last_idx;
  logic [BUS_W-1:0] slot_mask;

  function automatic logic [CNT_W-1:0] elem_count(input logic [1:0] size);
    case (size)
      2'b00:   return CNT_W'(4);
      2'b01:   return CNT_W'(9);
      2'b10:   return CNT_W'(16);
      default: return CNT_W'(25);
    endcase
  endfunction

  function automatic logic op_is_valid(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

  function automatic logic op_is_binary(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
  endfunction

  assign last_idx = elem_count(size_q) - CNT_W'(1);

  // Unit outputs beyond the active N slots are never allowed into the result.
  always_comb begin
    slot_mask = '0;
    for (int i = 0; i < MAX_ELEMS; i++) begin
      if (i < int'(elem_count(size_q))) slot_mask[i*8 +: 8] = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      exec_cnt    <= '0;
      op_q        <= '0;
      size_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cmd_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            if (op_is_valid(bus.cmd_op)) begin
              op_q        <= bus.cmd_op;
              size_q      <= bus.cmd_size;
              a_q         <= '0;
              b_q         <= '0;
              cnt         <= '0;
              cmd_ready_q <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b1;
              state       <= S_LOAD_A;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (bus.in_valid && in_ready_q) begin
            if (state == S_LOAD_A) a_q[cnt*8 +: 8] <= bus.in_data;
            else                   b_q[cnt*8 +: 8] <= bus.in_data;
            if (cnt == last_idx) begin
              cnt <= '0;
              if (state == S_LOAD_A && op_is_binary(op_q)) begin
                state <= S_LOAD_B;
              end else begin
                in_ready_q <= 1'b0;
                exec_cnt   <= '0;
                state      <= S_EXEC;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_EXEC: begin
          if (exec_cnt == EXEC_LAST) begin
            res_q       <= bus.unit_result & slot_mask;
            cnt         <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= (last_idx == '0);
            state       <= S_STREAM;
          end else begin
            exec_cnt <= exec_cnt + EXC_W'(1);
          end
        end
        S_STREAM: begin
          if (bus.out_ready && out_valid_q) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
              state       <= S_DONE;
            end else begin
              cnt        <= cnt + CNT_W'(1);
              out_last_q <= ((cnt + CNT_W'(1)) == last_idx);
            end
          end
        end
        S_DONE: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.unit_op   = op_q;
  assign bus.unit_size = size_q;
  assign bus.unit_a    = a_q;
  assign bus.unit_b    = b_q;
  assign bus.out_data  = res_q[cnt*8 +: 8];
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule
